// File: rtl/reg_bus_master.sv
// Initiator for the two-phase MCU register bus: an address strobe, then a data strobe (write) or a readback sample (read).
// Optional macro REG_BUS_ADDR_CACHE_EN skips the address phase when the target address matches the last one sent.
module reg_bus_master #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int READ_WAIT = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_WRITE,
  input  logic [4:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       BUSY,
  output logic       BUS_ADDR_OR_DATA,
  output logic       BUS_WRITE,
  output logic [7:0] BUS_DATA_OUT,
  input  logic [7:0] BUS_DATA_IN
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    A_SETUP = 3'd1,
    A_PULSE = 3'd2,
    A_HOLD  = 3'd3,
    D_SETUP = 3'd4,
    D_PULSE = 3'd5,
    D_HOLD  = 3'd6,
    R_WAIT  = 3'd7
  } state_t;

  localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] WAIT_LD  = 8'(READ_WAIT - 1);

  state_t     state_r, state_next_s;
  logic [7:0] cnt_r, cnt_next_s;
  logic       accept_s, cache_hit_s, rsp_valid_next_s;
  logic       aod_next_s;
  logic [7:0] dout_next_s, rsp_data_next_s;
  logic       req_ready_r, busy_r, rsp_valid_r, bus_aod_r, bus_write_r, write_r;
  logic [7:0] rsp_data_r, bus_dout_r, data_r;

`ifdef REG_BUS_ADDR_CACHE_EN
  logic       cache_valid_r, set_cache_s;
  logic [4:0] last_addr_r;
`endif

  // Each state's dwell is (N-1) on the shared down-counter; advance on zero.
  function automatic logic [7:0] load_value(input state_t s);
    logic [7:0] v;
    case (s)
      A_SETUP, D_SETUP: v = SETUP_LD;
      A_PULSE, D_PULSE: v = PULSE_LD;
      A_HOLD,  D_HOLD:  v = HOLD_LD;
      R_WAIT:           v = WAIT_LD;
      default:          v = 8'd0;
    endcase
    return v;
  endfunction

  // Address-cache hit detection on the request about to be accepted.
`ifdef REG_BUS_ADDR_CACHE_EN
  assign cache_hit_s = cache_valid_r && (REQ_ADDR == last_addr_r);
`else
  assign cache_hit_s = 1'b0;
`endif

  // Next-state, counter and next-output logic.
  always_comb begin
    state_next_s     = state_r;
    accept_s         = 1'b0;
    aod_next_s       = bus_aod_r;
    dout_next_s      = bus_dout_r;
    rsp_valid_next_s = 1'b0;
    rsp_data_next_s  = rsp_data_r;
`ifdef REG_BUS_ADDR_CACHE_EN
    set_cache_s      = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (REQ_VALID) begin
          accept_s = 1'b1;
          if (cache_hit_s) begin
            if (REQ_WRITE) begin
              state_next_s = D_SETUP;
              aod_next_s   = 1'b0;
              dout_next_s  = REQ_DATA;
            end else begin
              state_next_s = R_WAIT;
            end
          end else begin
            state_next_s = A_SETUP;
            aod_next_s   = 1'b1;
            dout_next_s  = {3'b000, REQ_ADDR};
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      A_SETUP: if (cnt_r == 8'd0) state_next_s = A_PULSE; else state_next_s = A_SETUP;
      A_PULSE: if (cnt_r == 8'd0) state_next_s = A_HOLD;  else state_next_s = A_PULSE;
      A_HOLD: begin
        if (cnt_r == 8'd0) begin
`ifdef REG_BUS_ADDR_CACHE_EN
          set_cache_s = 1'b1;
`endif
          if (write_r) begin
            state_next_s = D_SETUP;
            aod_next_s   = 1'b0;
            dout_next_s  = data_r;
          end else begin
            state_next_s = R_WAIT;
          end
        end else begin
          state_next_s = A_HOLD;
        end
      end
      D_SETUP: if (cnt_r == 8'd0) state_next_s = D_PULSE; else state_next_s = D_SETUP;
      D_PULSE: if (cnt_r == 8'd0) state_next_s = D_HOLD;  else state_next_s = D_PULSE;
      D_HOLD:  if (cnt_r == 8'd0) state_next_s = IDLE;    else state_next_s = D_HOLD;
      R_WAIT: begin
        if (cnt_r == 8'd0) begin
          state_next_s     = IDLE;
          rsp_valid_next_s = 1'b1;
          rsp_data_next_s  = BUS_DATA_IN;
        end else begin
          state_next_s = R_WAIT;
        end
      end
      default: state_next_s = IDLE;
    endcase

    if (state_next_s != state_r) begin
      cnt_next_s = load_value(state_next_s);
    end else if (cnt_r != 8'd0) begin
      cnt_next_s = cnt_r - 8'd1;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // State, counter, captured request and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'h00;
      bus_aod_r   <= 1'b0;
      bus_write_r <= 1'b0;
      bus_dout_r  <= 8'h00;
      write_r     <= 1'b0;
      data_r      <= 8'h00;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      req_ready_r <= (state_next_s == IDLE);
      busy_r      <= (state_next_s != IDLE);
      rsp_valid_r <= rsp_valid_next_s;
      rsp_data_r  <= rsp_data_next_s;
      bus_aod_r   <= aod_next_s;
      bus_write_r <= (state_next_s == A_PULSE) || (state_next_s == D_PULSE);
      bus_dout_r  <= dout_next_s;
      if (accept_s) begin
        write_r <= REQ_WRITE;
        data_r  <= REQ_DATA;
      end
    end
  end

`ifdef REG_BUS_ADDR_CACHE_EN
  // last_addr tracks the in-flight address; it is trusted only once its address phase completes.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cache_valid_r <= 1'b0;
      last_addr_r   <= 5'd0;
    end else begin
      if (accept_s) last_addr_r <= REQ_ADDR;
      if (set_cache_s) cache_valid_r <= 1'b1;
    end
  end
`endif

  assign REQ_READY        = req_ready_r;
  assign BUSY             = busy_r;
  assign RSP_VALID        = rsp_valid_r;
  assign RSP_DATA         = rsp_data_r;
  assign BUS_ADDR_OR_DATA = bus_aod_r;
  assign BUS_WRITE        = bus_write_r;
  assign BUS_DATA_OUT     = bus_dout_r;

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed bench for reg_bus_master: default-parameter instance plus a SETUP=3/PULSE=1/HOLD=2/READ_WAIT=4 instance.
module tb_reg_bus_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       v, w, v2, w2;
  logic [4:0] a, a2;
  logic [7:0] d, din, d2, din2;
  logic       rdy, busy, rv, aod, bw;
  logic [7:0] rd, bdo;
  logic       rdy2, busy2, rv2, aod2, bw2;
  logic [7:0] rd2, bdo2;

  int checks = 0;
  int errors = 0;
  int rise_cnt = 0, arise_cnt = 0, rsp_cnt = 0, acc_cnt = 0;
  logic bw_prev = 1'b0;

  always #5 clk = ~clk;

  reg_bus_master dut (
    .CLK(clk), .RESET(rst), .REQ_VALID(v), .REQ_READY(rdy), .REQ_WRITE(w),
    .REQ_ADDR(a), .REQ_DATA(d), .RSP_VALID(rv), .RSP_DATA(rd), .BUSY(busy),
    .BUS_ADDR_OR_DATA(aod), .BUS_WRITE(bw), .BUS_DATA_OUT(bdo), .BUS_DATA_IN(din)
  );

  reg_bus_master #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2), .READ_WAIT(4)) dut2 (
    .CLK(clk), .RESET(rst), .REQ_VALID(v2), .REQ_READY(rdy2), .REQ_WRITE(w2),
    .REQ_ADDR(a2), .REQ_DATA(d2), .RSP_VALID(rv2), .RSP_DATA(rd2), .BUSY(busy2),
    .BUS_ADDR_OR_DATA(aod2), .BUS_WRITE(bw2), .BUS_DATA_OUT(bdo2), .BUS_DATA_IN(din2)
  );

  // Bus monitor on the default instance: strobe edges, response pulses, accepts.
  always @(posedge clk) begin
    if (bw && !bw_prev) begin
      rise_cnt++;
      if (aod) arise_cnt++;
    end
    bw_prev = bw;
    if (rv) rsp_cnt++;
    if (v && rdy) acc_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input bit sel, input bit wr, input logic [4:0] ad, input logic [7:0] dt,
                         output int busy_cyc, output int hi_cyc);
    int n;
    busy_cyc = 0;
    hi_cyc   = 0;
    n        = 0;
    if (sel) begin v2 = 1'b1; w2 = wr; a2 = ad; d2 = dt; end
    else     begin v  = 1'b1; w  = wr; a  = ad; d  = dt; end
    do begin
      @(negedge clk);
      n++;
      v  = 1'b0;
      v2 = 1'b0;
      if (sel ? busy2 : busy) busy_cyc++;
      if (sel ? bw2 : bw) hi_cyc++;
    end while (!(sel ? rdy2 : rdy) && n < 60);
    chk("txn_done", {31'd0, (sel ? rdy2 : rdy)}, 32'd1);
  endtask

  initial begin
    logic [8:0] exp_wr, exp_aod, exp_rdy;
    int b, h, base_rise, base_arise, base_rsp, base_acc, rdy_cnt, exp_b2, exp_ar2;

    rst = 1'b1; v = 1'b0; w = 1'b0; a = 5'd0; d = 8'h00; din = 8'h00;
    v2 = 1'b0; w2 = 1'b0; a2 = 5'd0; d2 = 8'h00; din2 = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rv}, 32'd0);
    chk("rst_rsp_data", {24'd0, rd}, 32'h00);
    chk("rst_bus_write", {31'd0, bw}, 32'd0);
    chk("rst_aod", {31'd0, aod}, 32'd0);
    chk("rst_dout", {24'd0, bdo}, 32'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, rdy}, 32'd1);

    // Write 0x03 <- 0xA5: cycle-by-cycle bus shape
    exp_wr  = 9'b001100110;
    exp_aod = 9'b000001111;
    exp_rdy = 9'b100000000;
    v = 1'b1; w = 1'b1; a = 5'h03; d = 8'hA5;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) v = 1'b0;
      chk($sformatf("w1_bw_c%0d", k), {31'd0, bw}, {31'd0, exp_wr[k-1]});
      chk($sformatf("w1_aod_c%0d", k), {31'd0, aod}, {31'd0, exp_aod[k-1]});
      chk($sformatf("w1_dout_c%0d", k), {24'd0, bdo}, (k <= 4) ? 32'h03 : 32'hA5);
      chk($sformatf("w1_rdy_c%0d", k), {31'd0, rdy}, {31'd0, exp_rdy[k-1]});
    end

    // Read 0x09: readback sampled at the end of the last wait cycle
    din = 8'h55;
    v = 1'b1; w = 1'b0; a = 5'h09;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) v = 1'b0;
      chk($sformatf("r1_rv_c%0d", k), {31'd0, rv}, (k == 7) ? 32'd1 : 32'd0);
      chk($sformatf("r1_busy_c%0d", k), {31'd0, busy}, (k <= 6) ? 32'd1 : 32'd0);
      if (k == 6) begin
        chk("r1_rd_before", {24'd0, rd}, 32'h00);
        din = 8'h1F;
      end
      if (k == 7) chk("r1_rd", {24'd0, rd}, 32'h1F);
    end
    base_rsp = rsp_cnt;
    run_txn(1'b0, 1'b1, 5'h04, 8'h77, b, h);
    chk("w2_rd_kept", {24'd0, rd}, 32'h1F);
    chk("w2_no_rsp", rsp_cnt - base_rsp, 32'd0);
    chk("w2_busy", b, 32'd8);

    // Three back-to-back writes with REQ_VALID held
    base_rise = rise_cnt; base_acc = acc_cnt; rdy_cnt = 0;
    v = 1'b1; w = 1'b1; a = 5'h01; d = 8'h11;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k == 20) v = 1'b0;
      if (rdy) rdy_cnt++;
    end
    chk("b2b_accepts", acc_cnt - base_acc, 32'd3);
    chk("b2b_rises", rise_cnt - base_rise, 32'd6);
    chk("b2b_idle_gaps", rdy_cnt, 32'd2);
    @(negedge clk);
    chk("b2b_final_ready", {31'd0, rdy}, 32'd1);

    // Reset during the address strobe of a read
    base_rsp = rsp_cnt;
    v = 1'b1; w = 1'b0; a = 5'h0A;
    @(negedge clk);
    v = 1'b0;
    @(negedge clk);
    chk("rst_mid_pulse_high", {31'd0, bw}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_bw", {31'd0, bw}, 32'd0);
    chk("rst_mid_ready", {31'd0, rdy}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_mid_no_rsp", rsp_cnt - base_rsp, 32'd0);
    run_txn(1'b0, 1'b1, 5'h02, 8'h3C, b, h);
    chk("rst_after_busy", b, 32'd8);
    chk("rst_after_hi", h, 32'd4);

    // Two reads of SRAM_DATA (0x0F)
`ifdef REG_BUS_ADDR_CACHE_EN
    exp_b2 = 2; exp_ar2 = 0;
`else
    exp_b2 = 6; exp_ar2 = 1;
`endif
    din = 8'hC3;
    run_txn(1'b0, 1'b0, 5'h0F, 8'h00, b, h);
    chk("sram_r1_busy", b, 32'd6);
    chk("sram_r1_rd", {24'd0, rd}, 32'hC3);
    base_arise = arise_cnt;
    din = 8'h5A;
    run_txn(1'b0, 1'b0, 5'h0F, 8'h00, b, h);
    chk("sram_r2_busy", b, exp_b2);
    chk("sram_r2_addr_strobes", arise_cnt - base_arise, exp_ar2);
    chk("sram_r2_rd", {24'd0, rd}, 32'h5A);

    // Non-default timing instance
    run_txn(1'b1, 1'b1, 5'h07, 8'h99, b, h);
    chk("p2_w_busy", b, 32'd12);
    chk("p2_w_hi", h, 32'd2);
    din2 = 8'hE1;
    run_txn(1'b1, 1'b0, 5'h08, 8'h00, b, h);
    chk("p2_r_busy", b, 32'd10);
    chk("p2_r_hi", h, 32'd1);
    chk("p2_r_rd", {24'd0, rd2}, 32'hE1);
    chk("p2_r_rv", {31'd0, rv2}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
